// File: rtl/conv2d_stream_engine.sv
// Streaming KxK 2-D convolution producing MAPS feature maps per window.
// Define CONV2D_RELU_EN to clamp negative map sums to zero before the output register.
module conv2d_stream_engine #(
    parameter int IMG_W     = 32,
    parameter int IMG_H     = 32,
    parameter int K         = 5,
    parameter int MAPS      = 6,
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    input  logic                                  in_sof,
    input  logic signed [IN_WIDTH-1:0]            in_pixel,
    input  logic                                  wt_we,
    input  logic [$clog2(MAPS*(K*K+1))-1:0]       wt_addr,
    input  logic signed [IN_WIDTH-1:0]            wt_data,
    output logic                                  out_valid,
    output logic [((IMG_H-K+1) > 1 ? $clog2(IMG_H-K+1) : 1)-1:0] out_row,
    output logic [((IMG_W-K+1) > 1 ? $clog2(IMG_W-K+1) : 1)-1:0] out_col,
    output logic [MAPS*OUT_WIDTH-1:0]             out_data
);

    localparam int NT  = K * K;
    localparam int NW  = MAPS * (NT + 1);
    localparam int AW  = $clog2(NW);
    localparam int XW  = $clog2(IMG_W);
    localparam int YW  = $clog2(IMG_H);
    localparam int OHW = (IMG_H - K + 1) > 1 ? $clog2(IMG_H - K + 1) : 1;
    localparam int OCW = (IMG_W - K + 1) > 1 ? $clog2(IMG_W - K + 1) : 1;

    logic [XW-1:0] r_col;
    logic [YW-1:0] r_row;
    logic [XW-1:0] w_col;
    logic [YW-1:0] w_row;
    logic          w_win_ok;

    // in_sof forces the accepted pixel to (0,0) whatever the counters hold
    always_comb begin
        w_col    = in_sof ? '0 : r_col;
        w_row    = in_sof ? '0 : r_row;
        w_win_ok = (w_row >= YW'(K - 1)) && (w_col >= XW'(K - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (in_valid) begin
            if (w_col == XW'(IMG_W - 1)) begin
                r_col <= '0;
                r_row <= (w_row == YW'(IMG_H - 1)) ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end
    end

    logic signed [IN_WIDTH-1:0] r_lb  [K-1][IMG_W];
    logic signed [IN_WIDTH-1:0] r_win [K][K];
    logic signed [IN_WIDTH-1:0] w_colv[K];

    // Row 0 of the column is the oldest image row
    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            w_colv[r] = r_lb[K-2-r][IMG_W-1];
        end
        w_colv[K-1] = in_pixel;
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_lb[0][0] <= in_pixel;
            for (int j = 1; j < K - 1; j++) begin
                r_lb[j][0] <= r_lb[j-1][IMG_W-1];
            end
            for (int j = 0; j < K - 1; j++) begin
                for (int i = 1; i < IMG_W; i++) begin
                    r_lb[j][i] <= r_lb[j][i-1];
                end
            end
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
                r_win[r][K-1] <= w_colv[r];
            end
        end
    end

    logic signed [IN_WIDTH-1:0] r_wt [NW];
    logic                       r_pw_we;
    logic [AW-1:0]              r_pw_addr;
    logic signed [IN_WIDTH-1:0] r_pw_data;

    // Writes land one edge late so the window completing on the write edge sees old weights
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pw_we   <= 1'b0;
            r_pw_addr <= '0;
            r_pw_data <= '0;
            for (int i = 0; i < NW; i++) begin
                r_wt[i] <= '0;
            end
        end else begin
            r_pw_we   <= wt_we && ({1'b0, wt_addr} < (AW + 1)'(NW));
            r_pw_addr <= wt_addr;
            r_pw_data <= wt_data;
            if (r_pw_we) begin
                r_wt[r_pw_addr] <= r_pw_data;
            end
        end
    end

    logic signed [2*IN_WIDTH-1:0] w_prod;
    logic signed [OUT_WIDTH-1:0]  w_sum [MAPS];
    logic signed [OUT_WIDTH-1:0]  w_act [MAPS];

    always_comb begin
        w_prod = '0;
        for (int m = 0; m < MAPS; m++) begin
            w_sum[m] = OUT_WIDTH'(r_wt[m*(NT+1)+NT]);
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    w_prod = (2*IN_WIDTH)'(r_win[r][c])
                           * (2*IN_WIDTH)'(r_wt[m*(NT+1)+r*K+c]);
                    w_sum[m] = w_sum[m] + OUT_WIDTH'(w_prod);
                end
            end
        end
    end

    always_comb begin
        for (int m = 0; m < MAPS; m++) begin
`ifdef CONV2D_RELU_EN
            w_act[m] = w_sum[m][OUT_WIDTH-1] ? '0 : w_sum[m];
`else
            w_act[m] = w_sum[m];
`endif
        end
    end

    logic                     r_wv;
    logic [OHW-1:0]           r_wrow;
    logic [OCW-1:0]           r_wcol;
    logic                     r_out_valid;
    logic [OHW-1:0]           r_out_row;
    logic [OCW-1:0]           r_out_col;
    logic [MAPS*OUT_WIDTH-1:0] r_out_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wv        <= 1'b0;
            r_wrow      <= '0;
            r_wcol      <= '0;
            r_out_valid <= 1'b0;
            r_out_row   <= '0;
            r_out_col   <= '0;
            r_out_data  <= '0;
        end else begin
            r_wv <= in_valid && w_win_ok;
            if (in_valid && w_win_ok) begin
                r_wrow <= OHW'(w_row - YW'(K - 1));
                r_wcol <= OCW'(w_col - XW'(K - 1));
            end
            r_out_valid <= r_wv;
            if (r_wv) begin
                r_out_row <= r_wrow;
                r_out_col <= r_wcol;
                for (int m = 0; m < MAPS; m++) begin
                    r_out_data[m*OUT_WIDTH +: OUT_WIDTH] <= w_act[m];
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_row   = r_out_row;
    assign out_col   = r_out_col;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Scoreboard bench for conv2d_stream_engine: default instance plus a
// small 8x6 / K=3 / 2-map instance.
module tb_conv2d_stream_engine;

    localparam int W  = 32;
    localparam int H  = 32;
    localparam int K  = 5;
    localparam int M  = 6;
    localparam int IW = 8;
    localparam int OW = 32;
    localparam int NT = K * K;
    localparam int NW = M * (NT + 1);
    localparam int AW = $clog2(NW);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic in_sof = 1'b0;
    logic [IW-1:0] in_pixel = '0;
    logic wt_we = 1'b0;
    logic [AW-1:0] wt_addr = '0;
    logic [IW-1:0] wt_data = '0;
    logic out_valid;
    logic [4:0] out_row;
    logic [4:0] out_col;
    logic [M*OW-1:0] out_data;

    conv2d_stream_engine dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
        .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
        .out_valid(out_valid), .out_row(out_row), .out_col(out_col),
        .out_data(out_data)
    );

    logic s_in_valid = 1'b0;
    logic s_in_sof = 1'b0;
    logic [7:0] s_in_pixel = '0;
    logic s_wt_we = 1'b0;
    logic [4:0] s_wt_addr = '0;
    logic [7:0] s_wt_data = '0;
    logic s_out_valid;
    logic [1:0] s_out_row;
    logic [2:0] s_out_col;
    logic [63:0] s_out_data;

    conv2d_stream_engine #(
        .IMG_W(8), .IMG_H(6), .K(3), .MAPS(2), .IN_WIDTH(8), .OUT_WIDTH(32)
    ) dut_s (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_sof(s_in_sof), .in_pixel(s_in_pixel),
        .wt_we(s_wt_we), .wt_addr(s_wt_addr), .wt_data(s_wt_data),
        .out_valid(s_out_valid), .out_row(s_out_row), .out_col(s_out_col),
        .out_data(s_out_data)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        int cyc;
        int row;
        int col;
        logic [M*OW-1:0] data;
    } exp_t;

    exp_t q[$];
    int tw [M][NT+1];
    int fr [H][W];
    int mrow = 0;
    int mcol = 0;
    int cyc = 0;
    int n_out = 0;
    int f_row, f_col, l_row, l_col;
    logic [OW-1:0] last_m0;

    always @(posedge clk) cyc++;

    function automatic logic [M*OW-1:0] model_out();
        logic [M*OW-1:0] v;
        int s;
        v = '0;
        for (int m = 0; m < M; m++) begin
            s = tw[m][NT];
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    s += fr[mrow-K+1+r][mcol-K+1+c] * tw[m][r*K+c];
`ifdef CONV2D_RELU_EN
            if (s < 0) s = 0;
`endif
            v[m*OW +: OW] = s;
        end
        return v;
    endfunction

    task automatic model_wr(input int a, input int d);
        if (a < NW) tw[a/(NT+1)][a%(NT+1)] = d;
    endtask

    task automatic accept(input int pix, input bit sof, input bit we,
                          input int wa, input int wd);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = sof;
        in_pixel = pix[IW-1:0];
        wt_we    = we;
        wt_addr  = wa[AW-1:0];
        wt_data  = wd[IW-1:0];
        if (sof) begin
            mrow = 0;
            mcol = 0;
        end
        fr[mrow][mcol] = pix;
        if (mrow >= K - 1 && mcol >= K - 1) begin
            e.cyc  = cyc + 2;
            e.row  = mrow - (K - 1);
            e.col  = mcol - (K - 1);
            e.data = model_out();
            q.push_back(e);
        end
        if (we) model_wr(wa, wd);
        if (mcol == W - 1) begin
            mcol = 0;
            mrow = (mrow == H - 1) ? 0 : mrow + 1;
        end else begin
            mcol++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = 1'b0;
            wt_we    = 1'b0;
        end
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        wt_we    = 1'b1;
        wt_addr  = a[AW-1:0];
        wt_data  = d[IW-1:0];
        model_wr(a, d);
    endtask

    task automatic frame(input bit gap);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                accept((r*32+c) % 128, r == 0 && c == 0, 1'b0, 0, 0);
                if (gap) idle(1);
            end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst && out_valid) begin
            n_out++;
            if (n_out == 1) begin
                f_row = out_row;
                f_col = out_col;
            end
            l_row = out_row;
            l_col = out_col;
            last_m0 = out_data[OW-1:0];
            if (q.size() == 0) begin
                check("unexpected_out", out_valid, 1'b0);
            end else begin
                e = q.pop_front();
                check("latency", cyc, e.cyc);
                check("row", out_row, e.row);
                check("col", out_col, e.col);
                for (int m = 0; m < M; m++)
                    check("data", out_data[m*OW +: OW], e.data[m*OW +: OW]);
            end
        end
    end

    int s_cnt = 0;
    int s_er = 0;
    int s_ec = 0;

    always @(posedge clk) begin
        #1;
        if (rst && s_out_valid) begin
            s_cnt++;
            check("s_row", s_out_row, s_er);
            check("s_col", s_out_col, s_ec);
            check("s_map0", s_out_data[31:0], 9);
            check("s_map1", s_out_data[63:32], 9);
            if (s_ec == 5) begin
                s_ec = 0;
                s_er++;
            end else begin
                s_ec++;
            end
        end
    end

    initial begin
        for (int m = 0; m < M; m++)
            for (int i = 0; i <= NT; i++) tw[m][i] = 0;
        repeat (3) @(negedge clk);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data[63:0], 64'd0);
        check("rst_row", out_row, 5'd0);
        check("rst_col", out_col, 5'd0);
        check("rst_s_valid", s_out_valid, 1'b0);
        rst = 1'b1;
        idle(2);

        wr(0, 1);
        n_out = 0;
        frame(1'b0);
        idle(5);
        check("impulse_count", n_out, 784);
        check("impulse_first_row", f_row, 0);
        check("impulse_first_col", f_col, 0);
        check("impulse_last_row", l_row, 27);
        check("impulse_last_col", l_col, 27);
        check("impulse_drain", q.size(), 0);

        n_out = 0;
        frame(1'b1);
        idle(5);
        check("gap_count", n_out, 784);
        check("gap_drain", q.size(), 0);

        n_out = 0;
        for (int i = 0; i < 10*32 + 7; i++)
            accept(((i/32)*32 + i%32) % 128, i == 0, 1'b0, 0, 0);
        frame(1'b0);
        idle(5);
        check("resync_count", n_out, 955);
        check("resync_drain", q.size(), 0);

        wr(NW, 99);
        wr(255, 99);
        n_out = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                accept((r*32+c) % 128, r == 0 && c == 0,
                       r == 5 && c == 10, 1*(NT+1)+NT, 3);
        idle(5);
        check("live_count", n_out, 784);
        check("live_drain", q.size(), 0);

        for (int m = 0; m < M; m++) begin
            for (int i = 0; i < NT; i++) wr(m*(NT+1)+i, -1);
            wr(m*(NT+1)+NT, 5);
        end
        n_out = 0;
        for (int i = 0; i < H*W; i++)
            accept(2, i == 0, 1'b0, 0, 0);
        idle(5);
        check("relu_count", n_out, 784);
`ifdef CONV2D_RELU_EN
        check("relu_value", last_m0, 32'h0);
`else
        check("relu_value", last_m0, 32'hFFFFFFD3);
`endif

        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 9; i++) begin
                @(negedge clk);
                s_wt_we   = 1'b1;
                s_wt_addr = 5'(m*10 + i);
                s_wt_data = 8'd1;
            end
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            s_wt_we    = 1'b0;
            s_in_valid = 1'b1;
            s_in_sof   = (i == 0);
            s_in_pixel = 8'd1;
        end
        @(negedge clk);
        s_in_valid = 1'b0;
        s_in_sof   = 1'b0;
        idle(5);
        check("small_count", s_cnt, 24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
